hanning_overlap_add: RTL and testbench

// - Synthesis counterpart of the Hanning analysis window: rebuilds a continuous sample stream from

---
 rtl/hanning_overlap_add_pkg.sv | 29 ++
 rtl/hanning_overlap_add_ram.sv | 30 +++
 rtl/hanning_overlap_add.sv | 143 ++++++++++++++
 tb/tb_hanning_overlap_add.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/hanning_overlap_add_pkg.sv
// Shared DSP definitions for the Hann analysis/synthesis chain.
// Sample/accumulator widths, default frame geometry, Q15 limits, saturation.
package hanning_overlap_add_pkg;

  localparam int SAMPLE_W      = 16;
  localparam int ACC_W         = SAMPLE_W + 1;
  localparam int OLA_N         = 256;
  localparam int OLA_FRAME_LEN = 512;
  localparam int OLA_HOP       = OLA_N / 2;

  localparam logic signed [SAMPLE_W-1:0] Q15_MAX  = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] Q15_MIN  = 16'sh8000;
  localparam logic signed [SAMPLE_W-1:0] Q15_HALF = 16'sh4000;

  // One guard bit: overflow iff the two top bits disagree.
  function automatic logic signed [SAMPLE_W-1:0] sat_to_dw(
    input logic signed [ACC_W-1:0] x
  );
    logic signed [SAMPLE_W-1:0] r;
    if (!x[ACC_W-1] && x[ACC_W-2])
      r = Q15_MAX;
    else if (x[ACC_W-1] && !x[ACC_W-2])
      r = Q15_MIN;
    else
      r = x[SAMPLE_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/hanning_overlap_add_ram.sv
// Overlap-add accumulator ring: read-add-write port plus a write-zero port.
// Read is combinational so each entry is updated in a single cycle.
module ola_accum_ram
  import hanning_overlap_add_pkg::*;
#(
  parameter int N  = OLA_N,
  parameter int AW = ACC_W,
  localparam int LW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 i_add_en,
  input  logic [LW-1:0]        i_addr,
  input  logic signed [AW-1:0] i_add_data,
  output logic signed [AW-1:0] o_rdata,
  input  logic                 i_zero_en,
  input  logic [LW-1:0]        i_zaddr
);

  logic signed [AW-1:0] r_mem [N];

  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_zero_en)
      r_mem[i_zaddr] <= '0;
    if (i_add_en)
      r_mem[i_addr] <= r_mem[i_addr] + i_add_data;
  end

endmodule

// File: rtl/hanning_overlap_add.sv
// 50% overlap-add synthesis stage for Hann-windowed, zero-padded frames.
// Accepts FRAME_LEN samples per frame, emits HOP reconstructed samples.
module hanning_overlap_add
  import hanning_overlap_add_pkg::*;
#(
  parameter int N         = OLA_N,
  parameter int FRAME_LEN = OLA_FRAME_LEN,
  parameter int HOP       = N / 2,
  parameter int DW        = SAMPLE_W,
  parameter int AW        = ACC_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] sample_in,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic signed [DW-1:0] sample_out,
  output logic                 sample_out_valid,
  input  logic                 sample_out_ready
);

  localparam int LW = $clog2(N);
  localparam int IW = $clog2(FRAME_LEN);

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_PAD   = 2'd2;
  localparam logic [1:0] S_EMIT  = 2'd3;

  logic [1:0]           r_state;
  logic [IW-1:0]        r_idx;
  logic [LW-1:0]        r_base;
  logic [LW-1:0]        r_clr_ptr;
  logic [LW-1:0]        r_e;
  logic                 r_out_valid;
  logic signed [DW-1:0] r_out;

  logic                 w_in_xfer;
  logic                 w_out_xfer;
  logic                 w_add_en;
  logic                 w_zero_en;
  logic [LW-1:0]        w_acc_addr;
  logic [LW-1:0]        w_zaddr;
  logic signed [AW-1:0] w_add_data;
  logic signed [AW-1:0] w_rdata;

  assign sample_ready     = (r_state == S_ACCUM) || (r_state == S_PAD);
  assign sample_out       = r_out;
  assign sample_out_valid = r_out_valid;

  assign w_in_xfer  = sample_valid && sample_ready;
  assign w_out_xfer = r_out_valid && sample_out_ready;
  assign w_add_data = {{(AW-DW){sample_in[DW-1]}}, sample_in};

  // In EMIT the read port runs one word ahead of the zeroing port.
  always_comb begin
    w_add_en   = 1'b0;
    w_zero_en  = 1'b0;
    w_acc_addr = r_base + r_idx[LW-1:0];
    w_zaddr    = r_clr_ptr;
    unique case (r_state)
      S_CLEAR: w_zero_en = 1'b1;
      S_ACCUM: w_add_en  = w_in_xfer;
      S_EMIT: begin
        w_zaddr    = r_base + r_e;
        w_zero_en  = w_out_xfer;
        w_acc_addr = r_base + r_e + LW'(r_out_valid);
      end
      default: ;
    endcase
  end

  ola_accum_ram #(
    .N  (N),
    .AW (AW)
  ) u_ram (
    .clk        (clk),
    .i_add_en   (w_add_en),
    .i_addr     (w_acc_addr),
    .i_add_data (w_add_data),
    .o_rdata    (w_rdata),
    .i_zero_en  (w_zero_en),
    .i_zaddr    (w_zaddr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_CLEAR;
      r_idx       <= '0;
      r_base      <= '0;
      r_clr_ptr   <= '0;
      r_e         <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else begin
      unique case (r_state)
        S_CLEAR: begin
          r_clr_ptr <= r_clr_ptr + 1'b1;
          if (r_clr_ptr == LW'(N-1)) begin
            r_state <= S_ACCUM;
            r_idx   <= '0;
          end
        end
        S_ACCUM: begin
          if (w_in_xfer) begin
            r_idx <= r_idx + 1'b1;
            if (r_idx == IW'(N-1)) begin
              r_state <= (FRAME_LEN > N) ? S_PAD : S_EMIT;
              r_e     <= '0;
            end
          end
        end
        S_PAD: begin
          if (w_in_xfer) begin
            r_idx <= r_idx + 1'b1;
            if (r_idx == IW'(FRAME_LEN-1)) begin
              r_state <= S_EMIT;
              r_e     <= '0;
            end
          end
        end
        S_EMIT: begin
          if (!r_out_valid) begin
            r_out       <= sat_to_dw(w_rdata);
            r_out_valid <= 1'b1;
          end else if (sample_out_ready) begin
            if (r_e == LW'(HOP-1)) begin
              r_out_valid <= 1'b0;
              r_base      <= r_base + LW'(HOP);
              r_idx       <= '0;
              r_state     <= S_ACCUM;
            end else begin
              r_e   <= r_e + 1'b1;
              r_out <= sat_to_dw(w_rdata);
            end
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_hanning_overlap_add.sv
// Scoreboard bench for hanning_overlap_add: reference model is plain
// overlap-add of frame halves with saturation, checked by a monitor.
module tb_hanning_overlap_add;

  localparam int N   = 256;
  localparam int FL  = 512;
  localparam int HOP = 128;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] sample_in = '0;
  logic               sample_valid = 1'b0;
  logic               sample_ready;
  logic signed [15:0] sample_out;
  logic               sample_out_valid;
  logic               sample_out_ready = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int n_out  = 0;
  bit bp_on  = 0;
  bit stall  = 0;

  logic signed [15:0] exp_q [$];
  logic signed [15:0] frm [N];
  int                 tail [HOP];

  always #5 clk = ~clk;

  hanning_overlap_add dut (
    .clk              (clk),
    .rst              (rst),
    .sample_in        (sample_in),
    .sample_valid     (sample_valid),
    .sample_ready     (sample_ready),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid),
    .sample_out_ready (sample_out_ready)
  );

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Output j of a frame = this frame's first half + previous frame's second half.
  task automatic model_frame();
    for (int j = 0; j < HOP; j++) begin
      exp_q.push_back(16'(sat16(int'(frm[j]) + tail[j])));
      tail[j] = int'(frm[j+HOP]);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int j = 0; j < HOP; j++) tail[j] = 0;
  endtask

  task automatic put(input logic [15:0] x);
    int guard;
    guard = 0;
    @(negedge clk);
    sample_in    = x;
    sample_valid = 1'b1;
    while (!sample_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 20000) begin
        n_fail++;
        $display("FAIL input_timeout actual=stuck expected=sample_ready");
        $fatal(1, "input handshake timeout");
      end
    end
    @(posedge clk);
    #1 sample_valid = 1'b0;
  endtask

  task automatic send_frame(input bit pad_rand, input logic [15:0] pad_val);
    model_frame();
    for (int i = 0; i < N; i++) put(frm[i]);
    for (int i = 0; i < FL - N; i++)
      put(pad_rand ? 16'($urandom) : pad_val);
  endtask

  task automatic fill_const(input logic [15:0] v);
    for (int i = 0; i < N; i++) frm[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) frm[i] = 16'($urandom);
  endtask

  task automatic wait_out(input int target);
    int guard;
    guard = 0;
    while (n_out < target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("wait_out_reached", int'(n_out >= target), 1);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic reset_and_clear();
    int  cnt;
    bit  vseen;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_out_valid", sample_out_valid, 0);
    check("rst_ready", sample_ready, 0);
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_out_data", sample_out, 0);
    rst   = 1'b0;
    cnt   = 0;
    vseen = 0;
    while (!sample_ready && cnt < 1000) begin
      if (sample_out_valid) vseen = 1;
      @(negedge clk);
      cnt++;
    end
    check("clear_cycles", cnt, N);
    check("clear_no_out_valid", vseen, 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall) sample_out_ready = 1'b0;
      else if (bp_on) sample_out_ready = ($urandom_range(0, 3) != 0);
      else sample_out_ready = 1'b1;
    end
  end

  initial begin
    logic signed [15:0] e;
    forever begin
      @(negedge clk);
      if (!rst && sample_out_valid) begin
        check("ready_low_in_emit", sample_ready, 0);
        if (sample_out_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL extra_word actual=%0h expected=none", sample_out);
          end else begin
            e = exp_q.pop_front();
            check("out_word", sample_out, e);
          end
          n_out++;
        end
      end
    end
  end

  initial begin
    int                 n0;
    logic signed [15:0] hold;
    model_reset();
    reset_and_clear();

    fill_const(16'h1000); send_frame(0, 16'h0000);
    fill_const(16'h1000); send_frame(0, 16'h0000);
    fill_const(16'h1000); send_frame(0, 16'h7FFF);
    fill_const(16'h7000); send_frame(0, 16'h0000);
    fill_const(16'h7000); send_frame(0, 16'h0000);
    fill_const(16'h9000); send_frame(0, 16'h0000);
    fill_const(16'h9000); send_frame(0, 16'h0000);
    wait_drain();

    n0 = n_out;
    fill_const(16'h1000); send_frame(0, 16'h0000);
    wait_out(n0 + 60);
    stall = 1;
    @(posedge clk);
    #2 hold = sample_out;
    n0 = n_out;
    repeat (10) begin
      @(negedge clk);
      check("stall_valid_held", sample_out_valid, 1);
      check("stall_data_held", sample_out, hold);
    end
    check("stall_no_transfer", n_out, n0);
    stall = 0;
    wait_drain();

    bp_on = 1;
    for (int f = 0; f < 4; f++) begin
      fill_rand();
      send_frame(1, 16'h0000);
    end
    wait_drain();
    bp_on = 0;

    n0 = n_out;
    fill_rand();
    send_frame(1, 16'h0000);
    wait_out(n0 + 40);
    reset_and_clear();
    n0 = n_out;
    fill_const(16'h1000); send_frame(0, 16'h0000);
    wait_drain();
    check("post_reset_word_count", n_out - n0, HOP);

    repeat (5) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
